// File: rtl/calc_datapath.sv
// Calculator datapath: operand/function/result registers driven by controller strobes,
// single-cycle add/sub/logic and a WIDTH-step shift-add multiply / restoring divide engine.
module calc_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [2:0]           fct_i,
    input  logic                 a_we_i,
    input  logic                 a_rst_i,
    input  logic                 b_we_i,
    input  logic                 b_rst_i,
    input  logic                 fct_we_i,
    input  logic                 fct_rst_i,
    input  logic                 res_we_i,
    input  logic                 res_rst_i,
    input  logic                 rem_we_i,
    input  logic                 rem_rst_i,
    input  logic                 done_we_i,
    input  logic                 done_rst_i,
    output logic [2*WIDTH-1:0]   res_o,
    output logic [WIDTH-1:0]     rem_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, ZDIV} state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2:0]           fct_q;
    logic [2*WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]     rem_stage, rem_q;
    logic                 done_q, pend_done, err_q;
    logic [CNT_W-1:0]     cnt;
    logic                 eng_div;
    logic [WIDTH-1:0]     hi_q, lo_q, op_q;

    logic [2*WIDTH-1:0]   alu_res;
    logic                 iterative;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     hi_nx, lo_nx;
    logic                 last_step, complete, abort;

    assign iterative = (fct_q == 3'b010) || (fct_q == 3'b011);
    assign last_step = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign abort     = (state != IDLE) && res_rst_i;
    assign complete  = (last_step || (state == ZDIV)) && !res_rst_i;

    always_comb begin
        alu_res = '0;
        case (fct_q)
            3'b000:  alu_res = {{(WIDTH-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}};
            3'b001:  alu_res = {{(WIDTH-1){1'b0}}, {1'b0, a_q} - {1'b0, b_q}};
            3'b100:  alu_res = {{WIDTH{1'b0}}, a_q & b_q};
            3'b101:  alu_res = {{WIDTH{1'b0}}, a_q | b_q};
            3'b110:  alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            3'b111:  alu_res = {{WIDTH{1'b0}}, ~a_q};
            default: alu_res = '0;
        endcase
    end

    // One engine step: multiply shifts {acc_hi, multiplier} right; divide shifts {rem, quotient} left.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, op_q};
        div_diff  = div_shift - {1'b0, op_q};
        if (eng_div) begin
            hi_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_nx = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            fct_q     <= '0;
            res_q     <= '0;
            rem_stage <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            pend_done <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
            eng_div   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            op_q      <= '0;
        end else begin
            if (a_rst_i)        a_q <= '0;
            else if (a_we_i)    a_q <= a_i;
            if (b_rst_i)        b_q <= '0;
            else if (b_we_i)    b_q <= b_i;
            if (fct_rst_i)      fct_q <= '0;
            else if (fct_we_i)  fct_q <= fct_i;

            if (rem_rst_i)                         rem_q <= '0;
            else if (rem_we_i && state == IDLE)    rem_q <= rem_stage;

            case (state)
                IDLE: begin
                    if (res_rst_i) begin
                        res_q <= '0;
                        err_q <= 1'b0;
                    end else if (res_we_i) begin
                        if (iterative) begin
                            err_q   <= 1'b0;
                            eng_div <= fct_q[0];
                            cnt     <= '0;
                            hi_q    <= '0;
                            if (fct_q[0] && b_q == '0) begin
                                state <= ZDIV;
                                lo_q  <= a_q;
                            end else begin
                                state <= RUN;
                                lo_q  <= fct_q[0] ? a_q : b_q;
                                op_q  <= fct_q[0] ? b_q : a_q;
                            end
                        end else begin
                            res_q     <= alu_res;
                            rem_stage <= '0;
                        end
                    end
                end
                RUN: begin
                    if (res_rst_i) begin
                        state <= IDLE;
                        res_q <= '0;
                        err_q <= 1'b0;
                    end else begin
                        hi_q <= hi_nx;
                        lo_q <= lo_nx;
                        cnt  <= cnt + 1'b1;
                        if (last_step) begin
                            state     <= IDLE;
                            res_q     <= eng_div ? {{WIDTH{1'b0}}, lo_nx} : {hi_nx, lo_nx};
                            rem_stage <= eng_div ? hi_nx : '0;
                        end
                    end
                end
                ZDIV: begin
                    state <= IDLE;
                    if (res_rst_i) begin
                        res_q <= '0;
                        err_q <= 1'b0;
                    end else begin
                        res_q     <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                        rem_stage <= lo_q;
                        err_q     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A done request made while busy is held until the engine finishes.
            if (done_rst_i) begin
                done_q    <= 1'b0;
                pend_done <= 1'b0;
            end else if (state == IDLE) begin
                if (done_we_i) done_q <= 1'b1;
            end else if (abort) begin
                pend_done <= 1'b0;
            end else if (complete) begin
                if (pend_done || done_we_i) done_q <= 1'b1;
                pend_done <= 1'b0;
            end else if (done_we_i) begin
                pend_done <= 1'b1;
            end
        end
    end

    assign res_o  = res_q;
    assign rem_o  = rem_q;
    assign done_o = done_q;
    assign busy_o = (state != IDLE);
    assign err_o  = err_q;

endmodule

// File: tb/tb_calc_datapath.sv
// Scoreboard bench for calc_datapath: expected results queued at launch, compared when the engine goes idle.
module tb_calc_datapath;

    localparam int W = 8;

    logic              clk = 1'b0;
    logic              reset_i = 1'b0;
    logic [W-1:0]      a_i = '0, b_i = '0;
    logic [2:0]        fct_i = '0;
    logic              a_we_i = 0, a_rst_i = 0, b_we_i = 0, b_rst_i = 0, fct_we_i = 0, fct_rst_i = 0;
    logic              res_we_i = 0, res_rst_i = 0, rem_we_i = 0, rem_rst_i = 0, done_we_i = 0, done_rst_i = 0;
    logic [2*W-1:0]    res_o;
    logic [W-1:0]      rem_o;
    logic              done_o, busy_o, err_o;

    typedef struct {
        int res;
        int rem;
        int err;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    calc_datapath #(.WIDTH(W)) dut (
        .clock_i(clk), .reset_i(reset_i), .a_i(a_i), .b_i(b_i), .fct_i(fct_i),
        .a_we_i(a_we_i), .a_rst_i(a_rst_i), .b_we_i(b_we_i), .b_rst_i(b_rst_i),
        .fct_we_i(fct_we_i), .fct_rst_i(fct_rst_i), .res_we_i(res_we_i), .res_rst_i(res_rst_i),
        .rem_we_i(rem_we_i), .rem_rst_i(rem_rst_i), .done_we_i(done_we_i), .done_rst_i(done_rst_i),
        .res_o(res_o), .rem_o(rem_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int a, input int b, input int f);
        exp_t e;
        e.res = 0; e.rem = 0; e.err = 0; e.cyc = 0;
        case (f)
            0: e.res = a + b;
            1: e.res = (a - b) & 'h1FF;
            2: begin e.res = a * b; e.cyc = W; end
            3: begin
                if (b == 0) begin e.res = 'hFF; e.rem = a; e.err = 1; e.cyc = 1; end
                else begin e.res = a / b; e.rem = a % b; e.cyc = W; end
            end
            4: e.res = a & b;
            5: e.res = a | b;
            6: e.res = a ^ b;
            default: e.res = (~a) & 'hFF;
        endcase
        return e;
    endfunction

    task automatic set_ops(input int a, input int b, input int f);
        a_i = W'(a); b_i = W'(b); fct_i = 3'(f);
        a_we_i = 1; b_we_i = 1; fct_we_i = 1;
        tick();
        a_we_i = 0; b_we_i = 0; fct_we_i = 0;
    endtask

    task automatic launch(input bit new_a, input int a_alt);
        res_we_i = 1;
        if (new_a) begin a_i = W'(a_alt); a_we_i = 1; end
        tick();
        res_we_i = 0; a_we_i = 0;
    endtask

    task automatic wait_result(input string tag, input bit poke);
        exp_t e;
        int n = 0;
        while (busy_o && n < 50) begin
            n++;
            a_we_i = 0; done_we_i = 0;
            if (poke && n == 2) begin a_i = '1; a_we_i = 1; done_we_i = 1; end
            if (poke && n == 3) chk({tag, "_pend_done_low"}, done_o, 0);
            tick();
        end
        a_we_i = 0; done_we_i = 0;
        if (n >= 50) chk({tag, "_timeout"}, n, 0);
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = q.pop_front();
            chk({tag, "_res"}, res_o, e.res);
            chk({tag, "_err"}, err_o, e.err);
            chk({tag, "_busy_cycles"}, n, e.cyc);
            if (poke) chk({tag, "_done_at_completion"}, done_o, 1);
        end
    endtask

    task automatic do_op(input string tag, input int a, input int b, input int f,
                         input bit poke, input bit new_a, input int a_alt);
        set_ops(a, b, f);
        q.push_back(model(a, b, f));
        launch(new_a, a_alt);
        wait_result(tag, poke);
    endtask

    task automatic pulse_rem(input string tag, input int exp);
        rem_we_i = 1; tick(); rem_we_i = 0;
        chk(tag, rem_o, exp);
    endtask

    initial begin
        int lg_a[4] = '{'hF0, 'hF0, 'hF0, 'h5A};
        int lg_b[4] = '{'h3C, 'h3C, 'h3C, 'h00};
        int lg_f[4] = '{4, 5, 6, 7};

        reset_i = 1;
        tick();
        chk("rst_res", res_o, 0);
        chk("rst_rem", rem_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        tick();
        reset_i = 0;

        do_op("add", 200, 100, 0, 0, 0, 0);
        do_op("sub", 5, 7, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_op($sformatf("logic%0d", lg_f[i]), lg_a[i], lg_b[i], lg_f[i], 0, 0, 0);

        do_op("mul", 13, 11, 2, 1, 0, 0);
        done_rst_i = 1; tick(); done_rst_i = 0;
        chk("done_cleared", done_o, 0);

        do_op("div", 100, 7, 3, 0, 1, 50);
        pulse_rem("div_rem", model(100, 7, 3).rem);

        do_op("zdiv", 9, 0, 3, 0, 0, 0);
        pulse_rem("zdiv_rem", model(9, 0, 3).rem);
        res_rst_i = 1; tick(); res_rst_i = 0;
        chk("zdiv_rst_res", res_o, 0);
        chk("zdiv_rst_err", err_o, 0);

        set_ops(13, 11, 2);
        launch(0, 0);
        tick(); tick();
        reset_i = 1; tick(); reset_i = 0;
        chk("abort_rst_res", res_o, 0);
        chk("abort_rst_rem", rem_o, 0);
        chk("abort_rst_done", done_o, 0);
        chk("abort_rst_busy", busy_o, 0);
        chk("abort_rst_err", err_o, 0);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_rst_late_res", res_o, 0);
        chk("abort_rst_late_busy", busy_o, 0);

        set_ops(100, 7, 3);
        launch(0, 0);
        done_we_i = 1; tick(); done_we_i = 0;
        tick();
        res_rst_i = 1; tick(); res_rst_i = 0;
        chk("abort_rr_busy", busy_o, 0);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_rr_done", done_o, 0);
        chk("abort_rr_res", res_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
